// File: rtl/demux2_deser.sv
// demux2_deser: serial-to-parallel deserializer, LSB-first, with a valid/ready word output
module demux2_deser #(
  parameter int WLOG = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_clear,
  output logic [2**WLOG-1:0]   out_word,
  output logic [2**WLOG-1:0]   out_word_neg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WLOG-1:0]      bit_idx
);
  localparam int N = 2**WLOG;
  logic [WLOG-1:0] idx_q, idx_d;
  logic [N-1:0]    asm_q, asm_d, word_q, word_d;
  logic            valid_q, valid_d;
  logic            last, acc, done;
  assign last         = &idx_q;
  assign in_ready     = ~(last & valid_q & ~out_ready);
  assign acc          = in_valid & in_ready & ~in_clear;
  assign done         = acc & last;
  assign out_word     = word_q;
  assign out_word_neg = ~word_q;
  assign out_valid    = valid_q;
  assign bit_idx      = idx_q;
  always_comb begin
    asm_d = asm_q;
    if (acc) asm_d[idx_q] = in_bit;
    asm_d   = in_clear ? '0 : asm_d;
    idx_d   = in_clear ? '0 : acc ? idx_q + WLOG'(1) : idx_q;
    word_d  = done ? {in_bit, asm_q[N-2:0]} : word_q;
    valid_d = done | (valid_q & ~out_ready);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_demux2_deser.sv
// tb_demux2_deser: directed self-checking bench for demux2_deser at WLOG=5 and WLOG=2
module tb_demux2_deser;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit5, iv5, ir5, clr5, ov5, or5;
  logic [31:0] w5, wn5;
  logic [4:0]  idx5;
  logic        bit2, iv2, ir2, clr2, ov2, or2;
  logic [3:0]  w2, wn2;
  logic [1:0]  idx2;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  demux2_deser #(.WLOG(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_bit(bit5), .in_valid(iv5), .in_ready(ir5),
    .in_clear(clr5), .out_word(w5), .out_word_neg(wn5), .out_valid(ov5),
    .out_ready(or5), .bit_idx(idx5)
  );
  demux2_deser #(.WLOG(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_bit(bit2), .in_valid(iv2), .in_ready(ir2),
    .in_clear(clr2), .out_word(w2), .out_word_neg(wn2), .out_valid(ov2),
    .out_ready(or2), .bit_idx(idx2)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send5(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      iv5 = 1'b1;
      bit5 = w[i];
      tick();
    end
    iv5 = 1'b0;
  endtask
  task automatic send2(input logic [3:0] w, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      iv2 = 1'b1;
      bit2 = w[i];
      tick();
    end
    iv2 = 1'b0;
  endtask
  initial begin
    logic [31:0] pat;
    logic [3:0]  seq [3];
    rst_n = 1'b0;
    iv5 = 1'b1; bit5 = 1'b1; clr5 = 1'b0; or5 = 1'b1;
    iv2 = 1'b1; bit2 = 1'b1; clr2 = 1'b0; or2 = 1'b1;
    tick();
    tick();
    chk("rst_valid5", ov5, 0);
    chk("rst_word5", w5, 0);
    chk("rst_neg5", wn5, 32'hFFFF_FFFF);
    chk("rst_idx5", idx5, 0);
    chk("rst_valid2", ov2, 0);
    chk("rst_idx2", idx2, 0);
    chk("rst_neg2", wn2, 4'hF);
    rst_n = 1'b1;
    iv5 = 1'b0;
    iv2 = 1'b0;
    tick();
    pat = 32'hA5C3_0F81;
    send5(pat, 17);
    chk("mid_idx5", idx5, 17);
    chk("mid_valid5", ov5, 0);
    for (int i = 17; i < 31; i++) begin
      iv5 = 1'b1;
      bit5 = pat[i];
      tick();
    end
    chk("pre_valid5", ov5, 0);
    chk("pre_idx5", idx5, 31);
    bit5 = pat[31];
    tick();
    iv5 = 1'b0;
    chk("word5", w5, 32'hA5C3_0F81);
    chk("neg5", wn5, 32'h5A3C_F07E);
    chk("valid5", ov5, 1);
    chk("idx5_wrap", idx5, 0);
    tick();
    chk("consume_valid5", ov5, 0);
    chk("hold_word5", w5, 32'hA5C3_0F81);
    or2 = 1'b0;
    send2(4'h6, 0, 4);
    chk("bp_word6", w2, 4'h6);
    chk("bp_valid6", ov2, 1);
    send2(4'h9, 0, 3);
    chk("bp_idx3", idx2, 3);
    chk("bp_ready_low", ir2, 0);
    iv2 = 1'b1;
    bit2 = 1'b1;
    tick();
    chk("bp_stall_idx", idx2, 3);
    chk("bp_stall_word", w2, 4'h6);
    or2 = 1'b1;
    #1;
    chk("bp_ready_high", ir2, 1);
    tick();
    iv2 = 1'b0;
    chk("bp_word9", w2, 4'h9);
    chk("bp_valid9", ov2, 1);
    chk("bp_idx0", idx2, 0);
    tick();
    chk("bp_consumed", ov2, 0);
    seq[0] = 4'h3; seq[1] = 4'hC; seq[2] = 4'h5;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        iv2 = 1'b1;
        bit2 = seq[k][i];
        #1;
        chk("b2b_ready", ir2, 1);
        tick();
      end
      chk("b2b_word", w2, seq[k]);
      chk("b2b_valid", ov2, 1);
    end
    iv2 = 1'b0;
    tick();
    chk("b2b_drain", ov2, 0);
    send2(4'h3, 0, 2);
    chk("clr_idx2", idx2, 2);
    clr2 = 1'b1;
    iv2 = 1'b1;
    bit2 = 1'b1;
    tick();
    clr2 = 1'b0;
    iv2 = 1'b0;
    chk("clr_idx0", idx2, 0);
    chk("clr_valid", ov2, 0);
    chk("clr_word_hold", w2, 4'h5);
    send2(4'hA, 0, 4);
    chk("clr_wordA", w2, 4'hA);
    send5(32'hFFFF_FFFF, 17);
    chk("rst_mid_idx", idx5, 17);
    rst_n = 1'b0;
    iv5 = 1'b1;
    tick();
    rst_n = 1'b1;
    iv5 = 1'b0;
    chk("rst_mid_idx0", idx5, 0);
    chk("rst_mid_word", w5, 0);
    chk("rst_mid_neg", wn5, 32'hFFFF_FFFF);
    chk("rst_mid_valid", ov5, 0);
    send5(32'h0000_0001, 32);
    chk("rst_word1", w5, 32'h0000_0001);
    chk("rst_valid1", ov5, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux2_deser.md
Name: demux2_deser

Overview:
- Serial-to-parallel counterpart of the indexed bit-select mux.
- Accepts one bit per handshake and steers it into bit position `idx` of an assembly word, where `idx` is an internal WLOG-bit write index.
- After 2**WLOG bits, the completed word moves to an output holding register and is offered on a valid/ready interface.
- Sits between a bit-serial source and a word-wide consumer.

Parameters:
- WLOG, 5, index width. Word width N = 2**WLOG bits; the default gives N = 32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset. Sampled on the rising edge of clk.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is presented.
- in_ready  output  1  block accepts in_bit this cycle.
- in_clear  input  1  synchronous abort of the partial word.
- out_word  output  N  last completed word.
- out_word_neg  output  N  bitwise inverse of out_word, continuous.
- out_valid  output  1  out_word holds an unconsumed word.
- out_ready  input  1  consumer takes out_word this cycle.
- bit_idx  output  WLOG  current write index (position of the next accepted bit).

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - idx = 0, assembly register = 0, out_word = 0, out_valid = 0.
  - out_word_neg therefore = all ones.
  - Reset overrides every other input.
- Accept: an input bit is accepted on a rising edge where in_valid & in_ready = 1.
  - asm[idx] <= in_bit.
  - idx <= idx + 1, modulo N (wraps N-1 -> 0).
  - Ordering is LSB-first: the first bit of a word lands in bit 0.
- Completion: an accept with idx = N-1.
  - out_word <= {in_bit, asm[N-2:0]}.
  - out_valid <= 1.
  - idx <= 0.
  - Word latency: out_valid rises the cycle after the N-th accepted bit.
- in_ready:
  - in_ready = ~(idx == N-1 & out_valid & ~out_ready).
  - The block stalls only when the completing bit would overwrite an unconsumed word.
  - in_ready is combinational from out_ready and registered state, and has no dependency on in_valid.
- Output handshake:
  - A word is consumed on a rising edge where out_valid & out_ready = 1.
  - If no completion happens in that same cycle, out_valid <= 0.
  - out_word holds its value until the next completion; it is not cleared on consume.
- Simultaneous consume and completion: out_valid stays 1 and out_word takes the new word with no bubble.
- in_clear = 1 at an edge:
  - idx <= 0 and asm <= 0.
  - Any input bit presented that cycle is dropped.
  - out_word and out_valid are unaffected, and a consume that cycle still takes effect.
  - in_clear takes priority over an accept.
- Index and state:
  - bit_idx = idx, registered.
  - There is no separate FSM; the states are the index (0..N-1) crossed with the output register full/empty.
  - Bits of asm not yet written in the current word retain their prior values. They are always overwritten before completion, so they never reach out_word.
- in_valid = 0: no state change except an output consume.
- The block is fully synchronous on clk, with no latches.

Test Plan:
1. Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, out_word = 0, out_word_neg = 0xFFFFFFFF, bit_idx = 0, no accepts.
2. Single word, WLOG = 5, out_ready = 1: stream the 32 bits of 0xA5C3_0F81 LSB-first, one per cycle -> out_valid asserts one cycle after the 32nd bit with out_word = 0xA5C3_0F81, out_word_neg = 0x5A3C_F07E, bit_idx = 0.
3. Back-pressure, WLOG = 2: send 0x6, then 4 more bits encoding 0x9, with out_ready = 0 -> in_ready drops when bit_idx = 3; out_word holds 0x6. Raise out_ready -> the 4th bit is accepted the same cycle, out_word = 0x9, out_valid stays 1.
4. Back-to-back words, WLOG = 2: continuous in_valid with 0x3, 0xC, 0x5 and out_ready = 1 -> out_word sequence 0x3, 0xC, 0x5 on cycles 5, 9, 13; in_ready never deasserts.
5. Clear mid-word, WLOG = 2: accept 2 bits, assert in_clear together with in_valid -> bit_idx = 0 and that bit is dropped. Then send 0xA -> out_word = 0xA.
6. Reset mid-word, WLOG = 5: accept 17 bits, pull rst_n low for one cycle, then send 0x0000_0001 -> outputs clear during reset, out_word = 0x0000_0001 after 32 further bits.
